// File: rtl/synth_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : synth_config_sequencer
//  Description : Control front end for the FM synth pipeline. Generates the
//                {operator, voice} slot sequence with a frame strobe, decodes
//                and validates register writes into a write FIFO, and commits
//                buffered writes to the pipeline immediately or frame-aligned.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clock               clock
//    i_Reset               asynchronous active-high reset
//    i_Enable              slot counter advance enable
//    i_CommitMode          0 = immediate commit, 1 = frame-aligned commit
//    i_RegisterWriteEnable write request
//    i_RegisterWriteNumber {scope[1:0], param[5:0], op, voice}
//    i_RegisterWriteValue  write data
//    i_ClearOverflow       clears o_Overflow
//    o_RegisterWriteReady  FIFO not full
//    o_VoiceOperator       current slot {op, voice}
//    o_FrameStart          one-cycle pulse after the slot counter wraps
//    o_ConfigWriteEnable   one-cycle commit strobe
//    o_ConfigScope/Param/WriteAddr/WriteData  committed entry fields
//    o_FifoCount           entries pending
//    o_InvalidWrite        pulse: write rejected by decode
//    o_DroppedWrite        pulse: write rejected because the FIFO was full
//    o_Overflow            sticky drop flag
// ============================================================================
module synth_config_sequencer #(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  localparam int VB = $clog2(NUM_VOICES),
  localparam int OB = $clog2(NUM_OPERATORS),
  localparam int AW = 8 + OB + VB,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_CommitMode,
  input  logic                  i_RegisterWriteEnable,
  input  logic [AW-1:0]         i_RegisterWriteNumber,
  input  logic [DATA_WIDTH-1:0] i_RegisterWriteValue,
  input  logic                  i_ClearOverflow,
  output logic                  o_RegisterWriteReady,
  output logic [OB+VB-1:0]      o_VoiceOperator,
  output logic                  o_FrameStart,
  output logic                  o_ConfigWriteEnable,
  output logic [1:0]            o_ConfigScope,
  output logic [5:0]            o_ConfigParam,
  output logic [OB+VB-1:0]      o_ConfigWriteAddr,
  output logic [DATA_WIDTH-1:0] o_ConfigWriteData,
  output logic [CW-1:0]         o_FifoCount,
  output logic                  o_InvalidWrite,
  output logic                  o_DroppedWrite,
  output logic                  o_Overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = AW + DATA_WIDTH;

  localparam logic [VB-1:0] c_LAST_VOICE = VB'(NUM_VOICES - 1);
  localparam logic [OB-1:0] c_LAST_OP    = OB'(NUM_OPERATORS - 1);
  localparam logic [VB-1:0] c_VOICE_ONE  = VB'(1);
  localparam logic [OB-1:0] c_OP_ONE     = OB'(1);
  // One extra bit so that a power-of-two voice/operator count is representable.
  localparam logic [VB:0]   c_NUM_VOICES = (VB+1)'(NUM_VOICES);
  localparam logic [OB:0]   c_NUM_OPS    = (OB+1)'(NUM_OPERATORS);
  localparam logic [CW-1:0] c_DEPTH      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] c_LAST_PTR   = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] c_PTR_ONE    = PW'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [OB-1:0]         op_q, op_d;
  logic [VB-1:0]         voice_q, voice_d;
  logic                  frame_start_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         budget_q, budget_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic                  cfg_we_q;
  logic [1:0]            cfg_scope_q;
  logic [5:0]            cfg_param_q;
  logic [OB+VB-1:0]      cfg_addr_q;
  logic [DATA_WIDTH-1:0] cfg_data_q;
  logic                  invalid_q;
  logic                  dropped_q;
  logic                  overflow_q;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Slot counter
  // --------------------------------------------------------------------------
  logic w_last_voice;
  logic w_last_op;
  logic w_wrap;

  assign w_last_voice = (voice_q == c_LAST_VOICE);
  assign w_last_op    = (op_q == c_LAST_OP);
  assign w_wrap       = i_Enable & w_last_voice & w_last_op;

  always_comb begin
    op_d    = op_q;
    voice_d = voice_q;
    if (i_Enable) begin
      if (w_last_voice) begin
        voice_d = '0;
        op_d    = w_last_op ? '0 : op_q + c_OP_ONE;
      end else begin
        voice_d = voice_q + c_VOICE_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  logic [1:0]    w_scope;
  logic [OB-1:0] w_op;
  logic [VB-1:0] w_voice;
  logic          w_voice_ok;
  logic          w_op_ok;
  logic          w_valid;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_scope    = i_RegisterWriteNumber[AW-1 -: 2];
  assign w_op       = i_RegisterWriteNumber[OB+VB-1 -: OB];
  assign w_voice    = i_RegisterWriteNumber[VB-1:0];
  assign w_voice_ok = ({1'b0, w_voice} < c_NUM_VOICES);
  assign w_op_ok    = ({1'b0, w_op} < c_NUM_OPS);

  always_comb begin
    w_valid = 1'b0;
    case (w_scope)
      2'b01:   w_valid = 1'b1;                  // global: slot fields unused
      2'b10:   w_valid = w_voice_ok;            // per-voice: op field unused
      2'b11:   w_valid = w_voice_ok & w_op_ok;  // per-operator
      default: w_valid = 1'b0;
    endcase
  end

  // Full is judged on the pre-edge count, so a pop at the same edge does not
  // rescue a write presented against a full FIFO.
  assign w_full  = (count_q == c_DEPTH);
  assign w_push  = i_RegisterWriteEnable & w_valid & ~w_full;
  assign w_entry = {i_RegisterWriteNumber, i_RegisterWriteValue};
  assign w_head  = mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Commit scheduling
  // --------------------------------------------------------------------------
  // Immediate mode drains whenever anything is pending. Frame mode only pops
  // against the budget captured at the last wrap, so entries pushed after the
  // wrap wait for the following frame.
  assign w_pop = (count_q != '0) & (~i_CommitMode | (budget_q != '0));

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_ONE;
    end
  end

  always_comb begin
    budget_d = budget_q;
    if (!i_CommitMode) begin
      budget_d = '0;
    end else if (w_wrap) begin
      // Budget covers everything pending after the wrap edge, including a
      // write pushed on that very edge.
      budget_d = count_d;
    end else if (w_pop) begin
      budget_d = budget_q - c_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      op_q          <= '0;
      voice_q       <= '0;
      frame_start_q <= 1'b0;
      count_q       <= '0;
      budget_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cfg_we_q      <= 1'b0;
      cfg_scope_q   <= '0;
      cfg_param_q   <= '0;
      cfg_addr_q    <= '0;
      cfg_data_q    <= '0;
      invalid_q     <= 1'b0;
      dropped_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      op_q          <= op_d;
      voice_q       <= voice_d;
      frame_start_q <= w_wrap;
      count_q       <= count_d;
      budget_q      <= budget_d;
      invalid_q     <= i_RegisterWriteEnable & ~w_valid;
      dropped_q     <= i_RegisterWriteEnable & w_valid & w_full;
      cfg_we_q      <= w_pop;

      if (w_push) begin
        wr_ptr_q <= (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + c_PTR_ONE;
      end

      if (w_pop) begin
        rd_ptr_q    <= (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + c_PTR_ONE;
        cfg_scope_q <= w_head[EW-1 -: 2];
        cfg_param_q <= w_head[EW-3 -: 6];
        cfg_addr_q  <= w_head[DATA_WIDTH +: OB+VB];
        cfg_data_q  <= w_head[DATA_WIDTH-1:0];
      end

      // A new drop wins over a simultaneous clear.
      if (i_RegisterWriteEnable && w_valid && w_full) begin
        overflow_q <= 1'b1;
      end else if (i_ClearOverflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_RegisterWriteReady = ~w_full;
  assign o_VoiceOperator      = {op_q, voice_q};
  assign o_FrameStart         = frame_start_q;
  assign o_ConfigWriteEnable  = cfg_we_q;
  assign o_ConfigScope        = cfg_scope_q;
  assign o_ConfigParam        = cfg_param_q;
  assign o_ConfigWriteAddr    = cfg_addr_q;
  assign o_ConfigWriteData    = cfg_data_q;
  assign o_FifoCount          = count_q;
  assign o_InvalidWrite       = invalid_q;
  assign o_DroppedWrite       = dropped_q;
  assign o_Overflow           = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_synth_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_synth_config_sequencer
//  Description : Scoreboard bench for synth_config_sequencer with 24 voices,
//                6 operators and a 4-entry FIFO. Stimulus pushes expected
//                commits into a queue; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_synth_config_sequencer;

  localparam int NV = 24;
  localparam int NO = 6;
  localparam int DW = 16;
  localparam int FD = 4;

  localparam int EXP_OK   = 0;
  localparam int EXP_INV  = 1;
  localparam int EXP_DROP = 2;
  localparam int EXP_LOST = 3;

  typedef struct {
    logic [31:0] fields;
    int          slot;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, en, mode, we, clr;
  logic [15:0] num, val;
  logic        ready, fs, cfg_we, inv, drop, ovf;
  logic [7:0]  vo, addr;
  logic [1:0]  scope;
  logic [5:0]  param;
  logic [15:0] data;
  logic [2:0]  count;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  ent_t mon_e;

  always #5 clk = ~clk;

  synth_config_sequencer #(
    .NUM_VOICES(NV), .NUM_OPERATORS(NO), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_CommitMode(mode),
    .i_RegisterWriteEnable(we), .i_RegisterWriteNumber(num),
    .i_RegisterWriteValue(val), .i_ClearOverflow(clr),
    .o_RegisterWriteReady(ready), .o_VoiceOperator(vo), .o_FrameStart(fs),
    .o_ConfigWriteEnable(cfg_we), .o_ConfigScope(scope), .o_ConfigParam(param),
    .o_ConfigWriteAddr(addr), .o_ConfigWriteData(data), .o_FifoCount(count),
    .o_InvalidWrite(inv), .o_DroppedWrite(drop), .o_Overflow(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Present one write for one edge, then check the decode pulses it caused.
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input int kind, input int slot);
    ent_t e;
    we  = 1'b1;
    num = a;
    val = d;
    @(negedge clk);
    we  = 1'b0;
    chk("invalid_pulse", {31'd0, inv},  {31'd0, kind == EXP_INV});
    chk("dropped_pulse", {31'd0, drop}, {31'd0, kind == EXP_DROP});
    if (kind == EXP_OK) begin
      e.fields = {a, d};
      e.slot   = slot;
      q.push_back(e);
    end
  endtask

  task automatic wait_slot(input logic [7:0] s);
    int n = 0;
    while (vo !== s && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait_slot", {24'd0, vo}, {24'd0, s});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: every commit strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && cfg_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit act=%0h exp=none t=%0t",
                 {scope, param, addr, data}, $time);
      end else begin
        mon_e = q.pop_front();
        if ({scope, param, addr, data} !== mon_e.fields) begin
          errors++;
          $display("FAIL commit_fields act=%0h exp=%0h t=%0t",
                   {scope, param, addr, data}, mon_e.fields, $time);
        end
        if (mon_e.slot >= 0) begin
          checks++;
          if (vo !== mon_e.slot[7:0]) begin
            errors++;
            $display("FAIL commit_slot act=%0h exp=%0h t=%0t", vo, mon_e.slot[7:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, v;
    logic wrapped;
    rst = 1'b1; en = 1'b0; mode = 1'b0; we = 1'b0; clr = 1'b0;
    num = '0; val = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_slot", {24'd0, vo}, 0);
    chk("rst_fs", {31'd0, fs}, 0);
    chk("rst_cfg_we", {31'd0, cfg_we}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_flags", {29'd0, inv, drop, ovf}, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Slot sequence over one full frame plus a few slots
    op = 0; v = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      wrapped = (op == NO-1) && (v == NV-1);
      if (v == NV-1) begin
        v  = 0;
        op = (op == NO-1) ? 0 : op + 1;
      end else begin
        v = v + 1;
      end
      chk("slot", {24'd0, vo}, {24'd0, op[2:0], v[4:0]});
      chk("frame_start", {31'd0, fs}, {31'd0, wrapped});
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_slot", {24'd0, vo}, 8'h06);
    chk("hold_fs", {31'd0, fs}, 0);
    en = 1'b1;

    // Immediate mode: commit visible in the cycle after edge k+1
    wr(16'hC123, 16'h0400, EXP_OK, -1);
    chk("imm_count_after_push", {29'd0, count}, 1);
    @(negedge clk);
    chk("imm_commit_strobe", {31'd0, cfg_we}, 1);
    chk("imm_count_drained", {29'd0, count}, 0);

    // Decode boundaries
    wr(16'h0012, 16'h0001, EXP_INV, -1);   // scope 00
    chk("inv_count", {29'd0, count}, 0);
    wr(16'hC019, 16'h0002, EXP_INV, -1);   // voice 25
    wr(16'hC0E1, 16'h0003, EXP_INV, -1);   // op 7
    wr(16'h8018, 16'h0004, EXP_INV, -1);   // voice 24
    wr(16'h80F7, 16'h0005, EXP_OK, -1);    // voice 23, op ignored
    wr(16'h4019, 16'h0006, EXP_OK, -1);    // global, slot fields ignored
    wr(16'hC5B7, 16'h0007, EXP_OK, -1);    // op 5, voice 23
    repeat (3) @(negedge clk);
    chk("imm_idle_count", {29'd0, count}, 0);
    chk("imm_q_empty", q.size(), 0);

    // Frame mode: writes at slots 10..12 commit at slots 1..3
    mode = 1'b1;
    wait_slot(8'd10);
    wr(16'h4000, 16'h0001, EXP_OK, 1);
    wr(16'h8005, 16'h0002, EXP_OK, 2);
    wr(16'hC0A1, 16'h0003, EXP_OK, 3);
    chk("frame_pending", {29'd0, count}, 3);
    wait_slot(8'd0);
    chk("frame_wrap_fs", {31'd0, fs}, 1);
    chk("frame_no_early_commit", {29'd0, count}, 3);
    wr(16'hC205, 16'h0004, EXP_OK, 1);     // after the wrap: next frame
    wait_drain();

    // FIFO full, drops and sticky overflow
    wait_slot(8'd20);
    wr(16'h4101, 16'h0011, EXP_OK, 1);
    wr(16'h4202, 16'h0012, EXP_OK, 2);
    wr(16'h4303, 16'h0013, EXP_OK, 3);
    wr(16'h4404, 16'h0014, EXP_OK, 4);
    chk("full_ready", {31'd0, ready}, 0);
    chk("full_count", {29'd0, count}, 4);
    wr(16'h4505, 16'h0015, EXP_DROP, -1);
    chk("ovf_set", {31'd0, ovf}, 1);
    wr(16'h4606, 16'h0016, EXP_DROP, -1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {31'd0, ovf}, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 0);
    clr = 1'b1;
    wr(16'h4707, 16'h0017, EXP_DROP, -1);
    clr = 1'b0;
    chk("ovf_set_beats_clear", {31'd0, ovf}, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovf_cleared2", {31'd0, ovf}, 0);
    wait_drain();
    chk("ready_restored", {31'd0, ready}, 1);

    // Frame -> immediate switch drains pending entries at once
    wait_slot(8'd10);
    wr(16'h4808, 16'h0008, EXP_OK, -1);
    wr(16'h4909, 16'h0009, EXP_OK, -1);
    chk("switch_pending", {29'd0, count}, 2);
    mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("switch_drained", {29'd0, count}, 0);
    mode = 1'b1;

    // Asynchronous reset mid-drain
    wait_slot(8'd5);
    wr(16'h4A0A, 16'h00AA, EXP_OK, 1);
    wr(16'h4B0B, 16'h00BB, EXP_LOST, -1);
    wr(16'h4C0C, 16'h00CC, EXP_LOST, -1);
    wait_slot(8'd1);
    chk("mid_drain_count", {29'd0, count}, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_slot", {24'd0, vo}, 0);
    chk("async_cfg", {cfg_we, 1'b0, scope, param, addr, data[13:0]}, 0);
    chk("async_count", {29'd0, count}, 0);
    chk("async_ready", {31'd0, ready}, 1);
    @(negedge clk);
    we = 1'b1; num = 16'h4001; val = 16'h0001;   // ignored while in reset
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    chk("post_rst_count", {29'd0, count}, 0);
    repeat (160) @(negedge clk);
    chk("post_rst_no_commit", {29'd0, count}, 0);
    chk("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
